spmm_row_sched: RTL and testbench

Sequencer for one sparse-times-dense processing element in the SPMM stage. It pulls CSR row descriptors (row length) and the matching nonzero stream (column index, value), and drives the weight-BRAM read address. It presents value beats to the PE aligned with the BRAM's 1-cycle read latency, captures each row's accumulated result, and emits it on a valid/ready output tagged with the row index.

---
 rtl/spmm_row_sched_pkg.sv | 20 ++
 rtl/spmm_row_sched_if.sv | 66 ++++++
 rtl/spmm_row_sched_perf_cnt.sv | 28 ++
 rtl/spmm_row_sched.sv | 165 ++++++++++++++++
 tb/tb_spmm_row_sched.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmm_row_sched_pkg.sv
// Shared constants and FSM state encoding for the SPMM row scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spmm_row_sched_pkg;

    localparam int SPMM_DATA_WIDTH    = 8;
    localparam int SPMM_COL_IDX_WIDTH = 5;
    localparam int SPMM_ROW_LEN_WIDTH = 5;
    localparam int SPMM_WH_DATA_WIDTH = 16;
    localparam int SPMM_NUM_ROWS      = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STREAM  = 3'd1,
        DRAIN   = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/spmm_row_sched_if.sv
// Bundle of row-descriptor, nonzero, BRAM, PE and result signals of the row scheduler.
// Latency: n/a (wiring only).
// Backpressure: row/nz/res channels are valid/ready; BRAM and PE sides are not backpressured.
interface spmm_row_sched_if
    import spmm_row_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = SPMM_DATA_WIDTH,
    parameter int COL_IDX_WIDTH = SPMM_COL_IDX_WIDTH,
    parameter int ROW_LEN_WIDTH = SPMM_ROW_LEN_WIDTH,
    parameter int WH_DATA_WIDTH = SPMM_WH_DATA_WIDTH,
    parameter int NUM_ROWS      = SPMM_NUM_ROWS,
    parameter int ROW_IDX_WIDTH = $clog2(NUM_ROWS)
);

    logic                     row_vld_i;
    logic                     row_rdy_o;
    logic [ROW_LEN_WIDTH-1:0] row_len_i;

    logic                     nz_vld_i;
    logic                     nz_rdy_o;
    logic [COL_IDX_WIDTH-1:0] col_idx_i;
    logic [DATA_WIDTH-1:0]    val_i;

    logic                     wgt_en_o;
    logic [COL_IDX_WIDTH-1:0] wgt_addr_o;

    logic                     pe_vld_o;
    logic [DATA_WIDTH-1:0]    pe_val_o;
    logic                     pe_first_o;
    logic                     pe_last_o;
    logic [ROW_LEN_WIDTH-1:0] pe_row_len_o;
    logic [WH_DATA_WIDTH-1:0] pe_res_i;

    logic                     res_vld_o;
    logic                     res_rdy_i;
    logic [WH_DATA_WIDTH-1:0] res_data_o;
    logic [ROW_IDX_WIDTH-1:0] res_row_o;
    logic                     done_o;

    // Scheduler side.
    modport slave (
        input  row_vld_i, row_len_i,
        output row_rdy_o,
        input  nz_vld_i, col_idx_i, val_i,
        output nz_rdy_o,
        output wgt_en_o, wgt_addr_o,
        output pe_vld_o, pe_val_o, pe_first_o, pe_last_o, pe_row_len_o,
        input  pe_res_i,
        output res_vld_o, res_data_o, res_row_o, done_o,
        input  res_rdy_i
    );

    // Environment side: descriptor/nonzero source, PE, result sink.
    modport master (
        output row_vld_i, row_len_i,
        input  row_rdy_o,
        output nz_vld_i, col_idx_i, val_i,
        input  nz_rdy_o,
        input  wgt_en_o, wgt_addr_o,
        input  pe_vld_o, pe_val_o, pe_first_o, pe_last_o, pe_row_len_o,
        output pe_res_i,
        input  res_vld_o, res_data_o, res_row_o, done_o,
        output res_rdy_i
    );

endinterface

// File: rtl/spmm_row_sched_perf_cnt.sv
// Busy and stall cycle counters for the row scheduler, saturating at all-ones.
// Latency: count visible one cycle after the qualifying cycle.
// Backpressure: none; counters only observe.
module spmm_sched_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        busy_inc,
    input  logic        stall_inc,
    output logic [31:0] busy_cnt,
    output logic [31:0] stall_cnt
);

    // Saturating increment of both counters; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy_inc && (busy_cnt != '1)) begin
                busy_cnt <= busy_cnt + 32'd1;
            end
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/spmm_row_sched.sv
// Row sequencer for one SPMM PE: CSR row + nonzero stream in, BRAM address and PE beats out, row result out.
// Latency: BRAM addr same cycle as beat accept, PE beat +1, result valid 3 cycles after last beat (1 after empty row).
// Backpressure: one row in flight; descriptors/beats stall while the result waits on res_rdy_i. Optional SPMM_SCHED_PERF_CNT_EN adds perf counters.
module spmm_row_sched
    import spmm_row_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = SPMM_DATA_WIDTH,
    parameter int COL_IDX_WIDTH = SPMM_COL_IDX_WIDTH,
    parameter int ROW_LEN_WIDTH = SPMM_ROW_LEN_WIDTH,
    parameter int WH_DATA_WIDTH = SPMM_WH_DATA_WIDTH,
    parameter int NUM_ROWS      = SPMM_NUM_ROWS,
    parameter int ROW_IDX_WIDTH = $clog2(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    spmm_row_sched_if.slave     bus
`ifdef SPMM_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]         perf_busy_o,
    output logic [31:0]         perf_stall_o
`endif
);

    // One extra bit so the count can reach a full-length row without wrapping.
    localparam int CNT_WIDTH = ROW_LEN_WIDTH + 1;

    sched_state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic [ROW_LEN_WIDTH-1:0] len_q;
    logic [ROW_IDX_WIDTH-1:0] row_idx_q;
    logic [WH_DATA_WIDTH-1:0] res_q;
    logic                     pe_vld_q;
    logic                     pe_first_q;
    logic                     pe_last_q;
    logic [DATA_WIDTH-1:0]    pe_val_q;

    logic row_rdy;
    logic nz_rdy;
    logic res_vld;
    logic row_acc;
    logic nz_acc;
    logic res_acc;
    logic last_beat;
    logic row_wrap;

    assign row_acc   = bus.row_vld_i & row_rdy;
    assign nz_acc    = bus.nz_vld_i & nz_rdy;
    assign res_acc   = res_vld & bus.res_rdy_i;
    assign last_beat = (cnt_q == (CNT_WIDTH'(len_q) - CNT_WIDTH'(1)));
    assign row_wrap  = (row_idx_q == ROW_IDX_WIDTH'(NUM_ROWS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: empty rows skip straight to the result stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (row_acc) state_d = (bus.row_len_i == '0) ? OUT : STREAM;
            STREAM:  if (nz_acc && last_beat) state_d = DRAIN;
            DRAIN:   state_d = CAPTURE;
            CAPTURE: state_d = OUT;
            OUT:     if (res_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; held low while reset is asserted.
    always_comb begin
        row_rdy = 1'b0;
        nz_rdy  = 1'b0;
        res_vld = 1'b0;
        case (state_q)
            IDLE:    row_rdy = ~rst;
            STREAM:  nz_rdy  = ~rst;
            OUT:     res_vld = ~rst;
            default: ;
        endcase
    end

    // Row length latch, beat counter and PE beat pipeline (one stage, matching BRAM read latency).
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            cnt_q      <= '0;
            pe_vld_q   <= 1'b0;
            pe_first_q <= 1'b0;
            pe_last_q  <= 1'b0;
            pe_val_q   <= '0;
        end else begin
            pe_vld_q   <= 1'b0;
            pe_first_q <= 1'b0;
            pe_last_q  <= 1'b0;
            if (row_acc) begin
                cnt_q <= '0;
                if (bus.row_len_i != '0) begin
                    len_q <= bus.row_len_i;
                end
            end
            if (nz_acc) begin
                pe_vld_q   <= 1'b1;
                pe_val_q   <= bus.val_i;
                pe_first_q <= (cnt_q == '0);
                pe_last_q  <= last_beat;
                cnt_q      <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Result capture (PE output settles two cycles after the last beat) and row index advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q     <= '0;
            row_idx_q <= '0;
        end else begin
            if (row_acc && (bus.row_len_i == '0)) begin
                res_q <= '0;
            end else if (state_q == CAPTURE) begin
                res_q <= bus.pe_res_i;
            end
            if (res_acc) begin
                row_idx_q <= row_wrap ? '0 : (row_idx_q + ROW_IDX_WIDTH'(1));
            end
        end
    end

    assign bus.row_rdy_o    = row_rdy;
    assign bus.nz_rdy_o     = nz_rdy;
    assign bus.wgt_en_o     = nz_acc;
    assign bus.wgt_addr_o   = nz_acc ? bus.col_idx_i : '0;
    assign bus.pe_vld_o     = pe_vld_q;
    assign bus.pe_val_o     = pe_val_q;
    assign bus.pe_first_o   = pe_first_q;
    assign bus.pe_last_o    = pe_last_q;
    assign bus.pe_row_len_o = len_q;
    assign bus.res_vld_o    = res_vld;
    assign bus.res_data_o   = res_q;
    assign bus.res_row_o    = row_idx_q;
    assign bus.done_o       = res_acc & row_wrap;

`ifdef SPMM_SCHED_PERF_CNT_EN
    logic busy_inc;
    logic stall_inc;

    assign busy_inc  = (state_q != IDLE);
    assign stall_inc = ((state_q == STREAM) && !bus.nz_vld_i) ||
                       ((state_q == OUT) && !bus.res_rdy_i);

    spmm_sched_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .busy_inc  (busy_inc),
        .stall_inc (stall_inc),
        .busy_cnt  (perf_busy_o),
        .stall_cnt (perf_stall_o)
    );
`endif

endmodule

// File: tb/tb_spmm_row_sched.sv
// Testbench for spmm_row_sched with a stub weight BRAM and accumulating PE.
// Latency: n/a.
// Backpressure: result sink toggles res_rdy_i in the hold scenario.
module tb_spmm_row_sched;

    localparam int DW = 8;
    localparam int CW = 5;
    localparam int LW = 5;
    localparam int WW = 16;
    localparam int NR = 4;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spmm_row_sched_if #(
        .DATA_WIDTH(DW), .COL_IDX_WIDTH(CW), .ROW_LEN_WIDTH(LW),
        .WH_DATA_WIDTH(WW), .NUM_ROWS(NR), .ROW_IDX_WIDTH(RW)
    ) bus ();

`ifdef SPMM_SCHED_PERF_CNT_EN
    logic [31:0] perf_busy;
    logic [31:0] perf_stall;
`endif

    spmm_row_sched #(
        .DATA_WIDTH(DW), .COL_IDX_WIDTH(CW), .ROW_LEN_WIDTH(LW),
        .WH_DATA_WIDTH(WW), .NUM_ROWS(NR), .ROW_IDX_WIDTH(RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SPMM_SCHED_PERF_CNT_EN
        ,
        .perf_busy_o  (perf_busy),
        .perf_stall_o (perf_stall)
`endif
    );

    // Stub weight BRAM (1-cycle read) and PE accumulator.
    logic signed [7:0]  wmem [32];
    logic signed [7:0]  wgt_dout = '0;
    logic signed [15:0] acc = '0;
    logic signed [7:0]  pv;
    assign pv = bus.pe_val_o;
    assign bus.pe_res_i = acc;

    always @(posedge clk) if (bus.wgt_en_o) wgt_dout <= wmem[bus.wgt_addr_o];
    always @(posedge clk) if (bus.pe_vld_o) acc <= (bus.pe_first_o ? 16'sd0 : acc) + 16'(pv) * 16'(wgt_dout);

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    typedef struct { int val; bit first; bit last; int len; } beat_t;
    typedef struct { int data; int row; } res_t;

    int    exp_addr [$];
    beat_t exp_beat [$];
    res_t  exp_res  [$];
    int    exp_row = 0;

    // Scoreboard monitors: pop and compare whenever the DUT presents something.
    always @(negedge clk) begin
        int a;
        beat_t b;
        res_t r;
        if (bus.wgt_en_o) begin
            if (exp_addr.size() == 0) chk("wgt_en_unexpected", 1, 0);
            else begin
                a = exp_addr.pop_front();
                chk("wgt_addr", bus.wgt_addr_o, a);
            end
        end
        if (bus.pe_vld_o) begin
            if (exp_beat.size() == 0) chk("pe_vld_unexpected", 1, 0);
            else begin
                b = exp_beat.pop_front();
                chk("pe_val", $signed(bus.pe_val_o), b.val);
                chk("pe_first", bus.pe_first_o, b.first);
                chk("pe_last", bus.pe_last_o, b.last);
                chk("pe_row_len", bus.pe_row_len_o, b.len);
            end
        end
        if (bus.res_vld_o && bus.res_rdy_i) begin
            if (exp_res.size() == 0) chk("res_unexpected", 1, 0);
            else begin
                r = exp_res.pop_front();
                chk("res_data", $signed(bus.res_data_o), r.data);
                chk("res_row", bus.res_row_o, r.row);
                chk("done_on_accept", bus.done_o, (r.row == NR - 1) ? 1 : 0);
                if (bus.done_o) done_cnt++;
            end
        end else if (bus.done_o) begin
            chk("done_spurious", 1, 0);
        end
    end

    // pe_vld history for the gap scenario.
    bit rec = 1'b0;
    bit pe_hist [$];
    always @(negedge clk) if (rec) pe_hist.push_back(bus.pe_vld_o);

    logic [4:0] b_col [32];
    int         b_val [32];
    int         b_gap [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_row(input int len, input int res);
        exp_res.push_back('{data: res, row: exp_row});
        exp_row = (exp_row + 1) % NR;
        bus.row_vld_i = 1'b1;
        bus.row_len_i = 5'(len);
        @(negedge clk);
        chk("row_rdy_idle", bus.row_rdy_o, 1);
        tick();
        bus.row_vld_i = 1'b0;
        for (int i = 0; i < len; i++) begin
            bus.nz_vld_i = 1'b0;
            repeat (b_gap[i]) tick();
            exp_addr.push_back(int'(b_col[i]));
            exp_beat.push_back('{val: b_val[i], first: (i == 0), last: (i == len - 1), len: len});
            bus.nz_vld_i  = 1'b1;
            bus.col_idx_i = b_col[i];
            bus.val_i     = 8'(b_val[i]);
            tick();
        end
        bus.nz_vld_i = 1'b0;
    endtask

    task automatic wait_res(input int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_vld_o && n < 40);
        chk("res_latency", n, lat);
        tick();
    endtask

    task automatic check_outputs_zero();
        chk("z_row_rdy", bus.row_rdy_o, 0);
        chk("z_nz_rdy", bus.nz_rdy_o, 0);
        chk("z_wgt_en", bus.wgt_en_o, 0);
        chk("z_wgt_addr", bus.wgt_addr_o, 0);
        chk("z_pe_vld", bus.pe_vld_o, 0);
        chk("z_pe_val", bus.pe_val_o, 0);
        chk("z_pe_first", bus.pe_first_o, 0);
        chk("z_pe_last", bus.pe_last_o, 0);
        chk("z_pe_row_len", bus.pe_row_len_o, 0);
        chk("z_res_vld", bus.res_vld_o, 0);
        chk("z_res_data", bus.res_data_o, 0);
        chk("z_res_row", bus.res_row_o, 0);
        chk("z_done", bus.done_o, 0);
    endtask

    task automatic set_beat(input int i, input int col, input int val);
        b_col[i] = 5'(col);
        b_val[i] = val;
    endtask

    bit exp_pat [8] = '{0, 0, 1, 0, 0, 1, 0, 0};

    initial begin
        for (int i = 0; i < 32; i++) begin
            wmem[i]  = '0;
            b_col[i] = '0;
            b_val[i] = 0;
            b_gap[i] = 0;
        end
        wmem[0] = 8'sd1;  wmem[1] = -8'sd1; wmem[2] = 8'sd2;
        wmem[3] = 8'sd3;  wmem[4] = 8'sd5;  wmem[7] = 8'sd1;

        bus.row_vld_i = 1'b0; bus.row_len_i = '0;
        bus.nz_vld_i  = 1'b0; bus.col_idx_i = '0; bus.val_i = '0;
        bus.res_rdy_i = 1'b1;

        // Power-on reset.
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_outputs_zero();
        tick();
        rst = 1'b0;

        // Row 0: len 3 -> 5*2 + (-3)*1 + 4*(-1) = 3.
        set_beat(0, 2, 5); set_beat(1, 7, -3); set_beat(2, 1, 4);
        issue_row(3, 3);
        wait_res(3);

        // Row 1: empty row.
        issue_row(0, 0);
        wait_res(1);

        // Row 2: len 2 gap-free -> 6*3 + (-2)*5 = 8.
        set_beat(0, 3, 6); set_beat(1, 4, -2);
        issue_row(2, 8);
        wait_res(3);

        // Row 3: same beats with a 2-cycle gap; done pulses on its accept.
        b_gap[1] = 2;
        rec = 1'b1;
        issue_row(2, 8);
        wait_res(3);
        rec = 1'b0;
        b_gap[1] = 0;
        chk("pe_hist_len", pe_hist.size(), 8);
        for (int i = 0; i < 8 && i < pe_hist.size(); i++) chk("pe_vld_pattern", pe_hist[i], exp_pat[i]);

        // Row 0 (wrapped): result held under backpressure -> 3*(-1) = -3.
        set_beat(0, 1, 3);
        bus.res_rdy_i = 1'b0;
        issue_row(1, -3);
        wait_res(3);
        exp_res.push_back('{data: 0, row: exp_row});
        exp_row = (exp_row + 1) % NR;
        bus.row_vld_i = 1'b1;
        bus.row_len_i = '0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_res_vld", bus.res_vld_o, 1);
            chk("hold_res_data", $signed(bus.res_data_o), -3);
            chk("hold_res_row", bus.res_row_o, 0);
            chk("hold_row_rdy", bus.row_rdy_o, 0);
            chk("hold_nz_rdy", bus.nz_rdy_o, 0);
            tick();
        end
        bus.res_rdy_i = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("row_rdy_after_out", bus.row_rdy_o, 1);
        tick();
        bus.row_vld_i = 1'b0;
        wait_res(1);

        // Row 2: maximum length 31, all weight 1 -> 31.
        for (int i = 0; i < 31; i++) set_beat(i, 0, 1);
        issue_row(31, 31);
        wait_res(3);

        // Reset after 2 of 5 beats.
        for (int i = 0; i < 5; i++) set_beat(i, i + 1, i + 1);
        bus.row_vld_i = 1'b1;
        bus.row_len_i = 5'd5;
        @(negedge clk);
        tick();
        bus.row_vld_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_addr.push_back(int'(b_col[i]));
            exp_beat.push_back('{val: b_val[i], first: (i == 0), last: 1'b0, len: 5});
            bus.nz_vld_i  = 1'b1;
            bus.col_idx_i = b_col[i];
            bus.val_i     = 8'(b_val[i]);
            tick();
        end
        bus.nz_vld_i = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_outputs_zero();
        tick();
        rst = 1'b0;
        exp_row = 0;

        // Four len-1 rows tagged 0..3, then an empty row tagged 0.
        set_beat(0, 3, 7);  issue_row(1, 21);  wait_res(3);
        set_beat(0, 2, -4); issue_row(1, -8);  wait_res(3);
        set_beat(0, 7, 9);  issue_row(1, 9);   wait_res(3);
        set_beat(0, 1, 10); issue_row(1, -10); wait_res(3);
        issue_row(0, 0);
        wait_res(1);

        repeat (2) tick();
        chk("done_count", done_cnt, 2);
        chk("addr_q_empty", exp_addr.size(), 0);
        chk("beat_q_empty", exp_beat.size(), 0);
        chk("res_q_empty", exp_res.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
